// File: rtl/sram_mem_controller_if.sv
// CPU-side request/response bundle of the SRAM data-memory controller.
interface sram_mem_controller_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    // rd_en/wr_en act as valid and are held, together with address/write_data,
    // until ready is seen high; that cycle completes the transfer.
    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_mem_controller.sv
// Sequences 32-bit CPU accesses onto a 16-bit SRAM as two half-accesses, low half first.
// Optional one-entry read buffer is built when SRAM_READ_BUF_EN is defined.
module sram_mem_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_mem_controller_if.slave cpu,
    inout  wire  [15:0]          SRAM_DQ,
    output logic [17:0]          SRAM_ADDR,
    output logic                 SRAM_WE_N,
    output logic [1:0]           o_state
);
    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_op_wr;
    logic [16:0]     r_word;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic [CW-1:0]   r_wait;

    logic [16:0]     w_word;
    logic            w_req;
    logic            w_accept;
    logic            w_hit;
    logic            w_phase;
    logic            w_last;
    logic            w_dq_oe;
    logic [15:0]     w_dq_out;
    logic [31:0]     w_buf_rdata;

    // Out-of-range addresses simply wrap onto the 2^17-word SRAM.
    assign w_word  = 17'((cpu.address - BASE_ADDR) >> 2);
    assign w_req   = cpu.rd_en | cpu.wr_en;
    assign w_phase = (r_state == S_LOW) | (r_state == S_HIGH);
    assign w_last  = w_phase & (r_wait == WAIT_LAST);

`ifdef SRAM_READ_BUF_EN
    logic        r_buf_valid;
    logic [16:0] r_buf_tag;
    logic [31:0] r_buf_data;

    assign w_hit       = cpu.rd_en & ~cpu.wr_en & r_buf_valid & (r_buf_tag == w_word);
    assign w_buf_rdata = r_buf_data;

    // Write-through keeps the buffered copy coherent with the SRAM contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
        end else if ((r_state == S_IDLE) && cpu.wr_en && r_buf_valid && (r_buf_tag == w_word)) begin
            r_buf_data <= cpu.write_data;
        end else if ((r_state == S_HIGH) && w_last && !r_op_wr) begin
            r_buf_valid <= 1'b1;
            r_buf_tag   <= r_word;
            r_buf_data  <= {SRAM_DQ, r_rdata[15:0]};
        end
    end
`else
    assign w_hit       = 1'b0;
    assign w_buf_rdata = '0;
`endif

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_accept = 1'b1;
                    w_next   = w_hit ? S_DONE : S_LOW;
                end
            end
            S_LOW:   if (w_last) w_next = S_HIGH;
            S_HIGH:  if (w_last) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        w_dq_oe   = 1'b0;
        w_dq_out  = r_wdata[15:0];
        if (r_state == S_LOW) begin
            SRAM_ADDR = {r_word, 1'b0};
            SRAM_WE_N = ~r_op_wr;
            w_dq_oe   = r_op_wr;
        end else if (r_state == S_HIGH) begin
            SRAM_ADDR = {r_word, 1'b1};
            SRAM_WE_N = ~r_op_wr;
            w_dq_oe   = r_op_wr;
            w_dq_out  = r_wdata[31:16];
        end
    end

    assign SRAM_DQ       = w_dq_oe ? w_dq_out : 16'hzzzz;
    assign cpu.ready     = (r_state == S_DONE) | ((r_state == S_IDLE) & ~w_req);
    assign cpu.read_data = r_rdata;
    assign o_state       = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op_wr <= 1'b0;
            r_word  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_phase && !w_last) ? r_wait + CW'(1) : '0;
            if (w_accept) begin
                r_op_wr <= cpu.wr_en;
                r_word  <= w_word;
                r_wdata <= cpu.write_data;
            end
            if (w_accept && w_hit) begin
                r_rdata <= w_buf_rdata;
            end
            // Read data is captured on the final cycle of each held half.
            if (w_last && !r_op_wr) begin
                if (r_state == S_LOW) r_rdata[15:0]  <= SRAM_DQ;
                else                  r_rdata[31:16] <= SRAM_DQ;
            end
        end
    end
endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: two instances (WAIT_CYCLES=1 and 3), each on its own SRAM model.
module tb_sram_mem_controller;
  localparam logic [31:0] BASE = 32'd1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_mem_controller_if bus0();
  sram_mem_controller_if bus1();

  wire  [15:0] dq0, dq1;
  logic [17:0] sa0, sa1;
  logic        we0, we1;
  logic [1:0]  st0, st1;

  sram_mem_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .cpu(bus0),
    .SRAM_DQ(dq0), .SRAM_ADDR(sa0), .SRAM_WE_N(we0), .o_state(st0)
  );

  sram_mem_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .cpu(bus1),
    .SRAM_DQ(dq1), .SRAM_ADDR(sa1), .SRAM_WE_N(we1), .o_state(st1)
  );

  // shared requester, steered to one instance by sel
  bit          sel = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;

  assign bus0.rd_en      = rd_en & ~sel;
  assign bus0.wr_en      = wr_en & ~sel;
  assign bus0.address    = address;
  assign bus0.write_data = write_data;
  assign bus1.rd_en      = rd_en & sel;
  assign bus1.wr_en      = wr_en & sel;
  assign bus1.address    = address;
  assign bus1.write_data = write_data;

  wire        cur_ready = sel ? bus1.ready : bus0.ready;
  wire [31:0] cur_rdata = sel ? bus1.read_data : bus0.read_data;
  wire [17:0] cur_sa    = sel ? sa1 : sa0;
  wire        cur_we    = sel ? we1 : we0;

  // asynchronous SRAM models, 16-bit half-words
  logic [15:0] mem0 [0:262143];
  logic [15:0] mem1 [0:262143];
  assign dq0 = we0 ? mem0[sa0] : 16'hzzzz;
  assign dq1 = we1 ? mem1[sa1] : 16'hzzzz;
  always @(posedge clk) if (!we0) mem0[sa0] <= dq0;
  always @(posedge clk) if (!we1) mem1[sa1] <= dq1;

  // reference model: word-level memory, last read value, read-buffer tag
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd [2];
  bit          buf_v   [2];
  logic [16:0] buf_tag [2];

  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(input int key);
    return ref_mem.exists(key) ? ref_mem[key] : 32'd0;
  endfunction

  // monitor: a read completes where ready is seen while rd_en alone is held
  always @(negedge clk) begin
    if (!rst && cur_ready && rd_en && !wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got read completion expected none");
      end else begin
        check("read_data", cur_rdata, exp_q.pop_front());
      end
    end
  end

  // Called just after a falling edge with the selected controller idle.
  task automatic do_access(input bit s, input bit is_wr, input bit also_rd,
                           input logic [31:0] a, input logic [31:0] d);
    int          w = s ? 3 : 1;
    logic [16:0] word = 17'((a - BASE) >> 2);
    int          key = int'({s, word});
    bit          hit = 1'b0;
    int          exp_lat;
    int          c = 0;
    int          bad = 0;
    logic [17:0] ea;
    logic        ew;
    sel = s; address = a; write_data = d;
    wr_en = is_wr; rd_en = !is_wr || also_rd;
    if (is_wr) begin
      ref_mem[key] = d;
    end else begin
`ifdef SRAM_READ_BUF_EN
      hit = buf_v[s] && (buf_tag[s] == word);
      buf_v[s] = 1'b1;
      buf_tag[s] = word;
`endif
      last_rd[s] = ref_read(key);
      exp_q.push_back(last_rd[s]);
    end
    exp_lat = hit ? 1 : 2 * (w + 1) + 1;
    forever begin
      @(posedge clk);
      @(negedge clk);
      c++;
      if (!hit && c <= w + 1) begin
        ea = {word, 1'b0}; ew = !is_wr;
      end else if (!hit && c <= 2 * w + 2) begin
        ea = {word, 1'b1}; ew = !is_wr;
      end else begin
        ea = '0; ew = 1'b1;
      end
      if (cur_sa !== ea || cur_we !== ew) bad++;
      if (cur_ready) break;
      if (c >= 40) begin
        checks++;
        errors++;
        $display("FAIL timeout: got no ready after %0d cycles expected %0d", c, exp_lat);
        break;
      end
    end
    check("latency", c, exp_lat);
    check("sram_trace", bad, 0);
    if (is_wr) check("rdata_hold", cur_rdata, last_rd[s]);
    #1;
    rd_en = 1'b0; wr_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_ready", {31'd0, cur_ready}, 32'd1);
    #1;
  endtask

  initial begin
    last_rd[0] = '0; last_rd[1] = '0;
    buf_v[0] = 1'b0; buf_v[1] = 1'b0;
    buf_tag[0] = '0; buf_tag[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", {31'd0, bus0.ready}, 32'd1);
    check("rst_ready1", {31'd0, bus1.ready}, 32'd1);
    check("rst_rdata0", bus0.read_data, 32'd0);
    check("rst_we0",    {31'd0, we0}, 32'd1);
    check("rst_addr0",  {14'd0, sa0}, 32'd0);
    check("rst_addr1",  {14'd0, sa1}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk); #1;

    // write then read, half-addresses 4 and 5
    do_access(1'b0, 1'b1, 1'b0, BASE + 32'd8, 32'hDEADBEEF);
    check("half4", {16'd0, mem0[4]}, 32'h0000BEEF);
    check("half5", {16'd0, mem0[5]}, 32'h0000DEAD);
    do_access(1'b0, 1'b0, 1'b0, BASE + 32'd8, 32'h0);

    // reset during the low half of a write
    sel = 1'b0; address = BASE + 32'd800; write_data = 32'h55AA55AA; wr_en = 1'b1;
    @(posedge clk); @(negedge clk);
    check("mid_we", {31'd0, we0}, 32'd0);
    #1 rst = 1'b1; wr_en = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_mid_we",    {31'd0, we0}, 32'd1);
    check("rst_mid_addr",  {14'd0, sa0}, 32'd0);
    check("rst_mid_ready", {31'd0, bus0.ready}, 32'd1);
    check("rst_mid_rdata", bus0.read_data, 32'd0);
    check("rst_mid_dq",    {16'd0, dq0}, {16'd0, mem0[0]});
    #1 rst = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    buf_v[0] = 1'b0; buf_v[1] = 1'b0;
    @(negedge clk); #1;

    // simultaneous rd_en/wr_en is a write
    do_access(1'b0, 1'b1, 1'b1, BASE + 32'd12, 32'h12345678);
    do_access(1'b0, 1'b0, 1'b0, BASE + 32'd12, 32'h0);

    // address wrap onto word 0
    do_access(1'b0, 1'b1, 1'b0, BASE + 32'h0008_0000, 32'hCAFE0001);
    check("wrap_half0", {16'd0, mem0[0]}, 32'h00000001);
    check("wrap_half1", {16'd0, mem0[1]}, 32'h0000CAFE);
    do_access(1'b0, 1'b0, 1'b0, BASE, 32'h0);

    // fill words 0..63 of both memories
    for (int i = 0; i < 64; i++) begin
      do_access(1'b0, 1'b1, 1'b0, BASE + 32'(4 * i), $urandom);
      do_access(1'b1, 1'b1, 1'b0, BASE + 32'(4 * i), $urandom);
    end

    // WAIT_CYCLES=3 instance
    do_access(1'b1, 1'b1, 1'b0, BASE + 32'd40, 32'hA5A5_0F0F);
    do_access(1'b1, 1'b0, 1'b0, BASE + 32'd40, 32'h0);

    // read A, write A, read A, read B
    do_access(1'b0, 1'b0, 1'b0, BASE + 32'd80, 32'h0);
    do_access(1'b0, 1'b1, 1'b0, BASE + 32'd80, 32'h0BADF00D);
    do_access(1'b0, 1'b0, 1'b0, BASE + 32'd80, 32'h0);
    do_access(1'b0, 1'b0, 1'b0, BASE + 32'd84, 32'h0);

    // randomized mix
    for (int i = 0; i < 150; i++) begin
      bit          s = 1'($urandom_range(0, 1));
      bit          wr = ($urandom_range(0, 1) == 0);
      bit          both = wr && ($urandom_range(0, 3) == 0);
      logic [31:0] a;
      a = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a + 32'h0008_0000;
      do_access(s, wr, both, a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      #1;
    end

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Sequences 32-bit data-memory reads and writes from the CPU MEM stage onto the 16-bit external SRAM bus (SRAM_DQ, SRAM_ADDR, SRAM_WE_N).
- Each word access is split into two 16-bit half-accesses, low half first.
- Each half is held for a programmable number of wait cycles.
- `ready` is low while an access is in progress; the pipeline uses it as a freeze/stall.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 1: extra cycles each half-access is held; each half lasts WAIT_CYCLES+1 cycles.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rd_en  input  1  read request; held by requester until ready=1.
- wr_en  input  1  write request; held by requester until ready=1.
- address  input  32  byte address of the word.
- write_data  input  32  write word.
- read_data  output  32  last completed read word.
- ready  output  1  access complete / controller free.
- SRAM_DQ  inout  16  SRAM data bus; high-Z unless writing.
- SRAM_ADDR  output  18  SRAM half-word address.
- SRAM_WE_N  output  1  SRAM write enable, active low.

Behaviour:
- Reset (rst=1 at clk edge, including mid-operation): state=IDLE, SRAM_WE_N=1, SRAM_DQ=Z, SRAM_ADDR=0, read_data=0, wait counter=0, latched request cleared. An aborted write may leave the SRAM partially written; this is accepted.
- Word index: word = (address - BASE_ADDR) >> 2, truncated to 17 bits. Out-of-range addresses wrap modulo 2^17 and are not flagged.
- Half address: SRAM_ADDR = {word[16:0], h}, with h=0 in LOW and h=1 in HIGH. SRAM_ADDR=0 in IDLE and DONE.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if wr_en or rd_en is sampled, latch address, write_data and op, then go to LOW. wr_en has priority when both are asserted.
  - LOW: hold WAIT_CYCLES+1 cycles, counted by the wait counter, then go to HIGH.
  - HIGH: hold WAIT_CYCLES+1 cycles, then go to DONE.
  - DONE: one cycle, then go to IDLE.
- ready is combinational: ready = (state==DONE) | (state==IDLE & ~rd_en & ~wr_en).
- Latency: a request sampled in IDLE at cycle 0 gives ready=1 at cycle 2*(WAIT_CYCLES+1)+1. With the default this is cycle 5.
- Back-to-back requests: a request still asserted during DONE is not restarted. The requester advances on ready; a new request is accepted in the following IDLE cycle.
- Write phases (LOW/HIGH with op=write): SRAM_WE_N=0 for the whole phase.
  - SRAM_DQ = latched write_data[15:0] in LOW, write_data[31:16] in HIGH.
- Read phases: SRAM_WE_N=1, SRAM_DQ=Z.
  - SRAM_DQ is sampled on the last cycle of each phase, into read_data[15:0] (LOW) and read_data[31:16] (HIGH).
  - read_data is updated only by reads and holds its value otherwise, including across writes.
- Inputs are latched: changes to rd_en, wr_en, address or write_data after acceptance do not affect the access in flight. Dropping the request mid-access does not abort it.

Optional Feature:
- Macro: SRAM_READ_BUF_EN.
- With the macro defined, a one-entry read buffer holds a valid bit, a 17-bit word tag and 32-bit data.
  - The buffer is filled on every completed read.
  - A write whose word matches the tag updates the buffered data (write-through); the SRAM write still occurs with full latency.
  - A read in IDLE that hits (valid and tag match) goes straight to DONE. read_data is loaded from the buffer, no SRAM cycles are issued, and ready=1 at cycle 1.
  - rst clears the valid bit.
- Without the macro: no buffer is built; every read takes full latency.

Test Plan:
1. Reset mid-write: rst during a LOW write phase → next cycle state=IDLE, SRAM_WE_N=1, SRAM_DQ=Z, ready=1 with no request, read_data=0.
2. Write then read, WAIT_CYCLES=1:
   - Write 0xDEADBEEF to address 1024+8 → SRAM half-addresses 4 and 5 receive 0xBEEF then 0xDEAD; ready=0 for cycles 0–4, ready=1 at cycle 5.
   - Read of the same address → read_data=0xDEADBEEF at cycle 5.
3. Simultaneous rd_en=1 and wr_en=1 with write_data=0x12345678 → a write is performed; a later read returns 0x12345678.
4. Address wrap: write 0xCAFE0001 to BASE_ADDR + (2^17)*4 → lands on SRAM word 0 (half-addresses 0 and 1).
5. WAIT_CYCLES=3: read → ready=1 at cycle 9; SRAM_ADDR is held at {word,0} for exactly 4 cycles and {word,1} for 4 cycles.
6. With SRAM_READ_BUF_EN, read A, then write 0x0BADF00D to A, then read A → the second read gives ready=1 at cycle 1 with 0x0BADF00D and no SRAM address activity; a read of word B≠A takes full latency.
